// File: rtl/systolic_pkg.sv
// systolic_pkg: defaults, feeder FSM states and count type shared by the
// banked-buffer, skew-feeder and systolic-array stages.
package systolic_pkg;
    localparam int ARR_SIZE_DEF = 4;
    localparam int DATA_W_DEF   = 16;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;
    typedef logic [15:0] count_t;

    function automatic count_t sat_inc(input count_t c);
        return (c == 16'hFFFF) ? c : c + count_t'(1);
    endfunction
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage data/valid pipe; data is zeroed whenever its
// valid bit is low so idle slots read as 0 at the array edge.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= valid_i ? data_i : '0;
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: skews banked-buffer vectors into a diagonal wavefront (lane i
// delayed i+1 cycles) and tracks stream boundaries via last tags on lane N-1.
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int ARR_SIZE = ARR_SIZE_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ARR_SIZE*DATA_W-1:0] in_data,
    input  logic                       in_last,
    output logic [ARR_SIZE*DATA_W-1:0] out_data,
    output logic [ARR_SIZE-1:0]        out_valid,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                vec_count
);
    state_e              state_q, state_d;
    count_t              cnt_q, cnt_d, vc_q, vc_d;
    logic [ARR_SIZE-1:0] last_q;
    logic                acc_last, tail_clear;

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        skew_delay_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_line (
            .clk    (clk),
            .rst    (rst),
            .data_i (in_data[i*DATA_W +: DATA_W]),
            .valid_i(in_valid),
            .data_o (out_data[i*DATA_W +: DATA_W]),
            .valid_o(out_valid[i])
        );
    end

    assign acc_last = in_valid && in_last;
    // Only the tag now leaving may be in flight before DRAIN may retire to IDLE.
    assign tail_clear = ((last_q << 1) == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? (in_last ? DRAIN : STREAM) : IDLE;
            STREAM:  state_d = acc_last ? DRAIN : STREAM;
            DRAIN:   state_d = in_valid ? (in_last ? DRAIN : STREAM)
                                        : (done && tail_clear) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        cnt_d = !in_valid ? cnt_q : (state_q == STREAM) ? sat_inc(cnt_q) : count_t'(1);
        vc_d  = acc_last ? cnt_d : vc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vc_q    <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vc_q    <= vc_d;
            last_q  <= (last_q << 1) | ARR_SIZE'(acc_last);
        end
    end

    assign done      = last_q[ARR_SIZE-1];
    assign busy      = (state_q != IDLE);
    assign vec_count = vc_q;
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed scenarios plus randomized traffic checked against
// an acceptance-history model of the skew feeder.
module tb_skew_feeder;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int MAXC = 4096;

    logic              clk = 0;
    logic              rst = 1;
    logic              in_valid = 0;
    logic              in_last = 0;
    logic [N*DW-1:0]   in_data = '0;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_valid;
    logic              busy, done;
    logic [15:0]       vec_count;

    skew_feeder #(.ARR_SIZE(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    bit              hv[MAXC];
    bit              hl[MAXC];
    logic [N*DW-1:0] hd[MAXC];
    int              c = 0, base = 0;
    int              n_cmp = 0, n_err = 0;
    bit              open_s = 0;
    logic [15:0]     n_s = 0, vc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [N*DW-1:0] ed = '0;
        logic [N-1:0]    ev = '0;
        bit              ed_done = 0, eb = open_s;
        for (int i = 0; i < N; i++) begin
            int t = c - 1 - i;
            if (t >= base && hv[t]) begin
                ev[i] = 1;
                ed[i*DW +: DW] = hd[t][i*DW +: DW];
            end
        end
        for (int k = 1; k <= N; k++) begin
            int t = c - k;
            if (t >= base && hl[t]) begin
                eb = 1;
                if (k == N) ed_done = 1;
            end
        end
        check("out_valid", 64'(out_valid), 64'(ev));
        check("out_data", 64'(out_data), 64'(ed));
        check("done", 64'(done), 64'(ed_done));
        check("busy", 64'(busy), 64'(eb));
        check("vec_count", 64'(vec_count), 64'(vc));
    endtask

    // Called at a falling edge: check this cycle's outputs, then drive and record its inputs.
    task automatic step(input bit v, input bit l, input logic [N*DW-1:0] d);
        check_outputs();
        in_valid = v; in_last = l; in_data = d;
        hv[c] = v; hl[c] = v && l; hd[c] = d;
        if (v) begin
            n_s = open_s ? ((n_s == 16'hFFFF) ? n_s : n_s + 16'd1) : 16'd1;
            open_s = !l;
            if (l) vc = n_s;
        end
        c++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; in_last = 0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst vec_count", 64'(vec_count), 64'd0);
        @(negedge clk);
        rst = 0;
        c++;
        base = c; open_s = 0; n_s = 0; vc = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0);
    endtask

    function automatic logic [N*DW-1:0] kvec(input int k);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(16 * k + i);
        return v;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        idle(2);
        // single vector
        step(1, 1, {16'd4, 16'd3, 16'd2, 16'd1});
        idle(6);
        // five-vector stream
        for (int k = 0; k < 5; k++) step(1, k == 4, kvec(k));
        idle(6);
        // back-to-back streams of 3 and 2
        for (int k = 0; k < 5; k++) step(1, k == 2 || k == 4, kvec(k + 8));
        idle(6);
        // gapped stream
        for (int k = 0; k < 5; k++) step(k % 2 == 0, k == 4, kvec(k + 20));
        idle(6);
        // reset at cycle 2 of a five-vector stream, then a single vector
        for (int k = 0; k < 2; k++) step(1, 0, kvec(k + 30));
        do_reset();
        step(1, 1, {16'd4, 16'd3, 16'd2, 16'd1});
        idle(6);
        // in_last without in_valid is ignored
        step(0, 1, kvec(40));
        step(0, 1, kvec(41));
        idle(5);
        // randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            bit v = ($urandom_range(0, 99) < 65);
            bit l = ($urandom_range(0, 99) < 25);
            if ($urandom_range(0, 399) == 0) do_reset();
            else step(v, l, {$urandom, $urandom});
        end
        idle(6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
